// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, port ids, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} port_t;

  function automatic port_t other_port(input port_t p);
    return (p == FETCH) ? DATA : FETCH;
  endfunction

endpackage

// File: rtl/mem_arb_grant_sel.sv
// Combinational alternating-priority picker between the fetch and data ports.
module mem_arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic  fetch_req,
  input  logic  data_req,
  input  port_t last_grant,
  input  logic  exclude_en,
  input  port_t exclude_port,
  output port_t grant,
  output logic  grant_valid
);

  logic fetch_ok, data_ok;

  assign fetch_ok    = fetch_req && !(exclude_en && exclude_port == FETCH);
  assign data_ok     = data_req  && !(exclude_en && exclude_port == DATA);
  assign grant_valid = fetch_ok || data_ok;

  // On contention the port that did not win last time goes first.
  always_comb begin
    grant = FETCH;
    if (fetch_ok && data_ok) grant = other_port(last_grant);
    else if (data_ok)        grant = DATA;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates fetch and data ports onto the single-port word memory bus.
// Optional access timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inputFetchReq,
  input  logic [ADDR_W-1:0] inputFetchAddress,
  output logic [DATA_W-1:0] outputFetchRdata,
  output logic              outputFetchDone,
  input  logic              inputDataReq,
  input  logic              inputDataWnR,
  input  logic [ADDR_W-1:0] inputDataAddress,
  input  logic [DATA_W-1:0] inputDataWdata,
  output logic [DATA_W-1:0] outputDataRdata,
  output logic              outputDataDone,
  output logic              outputMemSelect,
  output logic              outputMemWnR,
  output logic [ADDR_W-1:0] outputMemAddress,
  output logic [DATA_W-1:0] outputMemWdata,
  input  logic [DATA_W-1:0] inputMemRdata,
  input  logic              inputMemValid,
  output logic              outputError
);

  state_t state_q, state_d;
  port_t  gnt_q, gnt_sel;
  logic   gnt_vld, load, finish, abort;
  logic [DATA_W-1:0] cap_data;

  // From DONE the just-served port is masked so its still-high req is not reissued.
  mem_arb_grant_sel u_grant_sel (
    .fetch_req    (inputFetchReq),
    .data_req     (inputDataReq),
    .last_grant   (gnt_q),
    .exclude_en   (state_q == DONE),
    .exclude_port (gnt_q),
    .grant        (gnt_sel),
    .grant_valid  (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (gnt_vld) begin
          load    = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (inputMemValid || abort) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap_data = (abort || outputMemWnR) ? '0 : inputMemRdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      gnt_q            <= FETCH;
      outputMemSelect  <= 1'b0;
      outputMemWnR     <= 1'b0;
      outputMemAddress <= '0;
      outputMemWdata   <= '0;
      outputFetchRdata <= '0;
      outputDataRdata  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        gnt_q            <= gnt_sel;
        outputMemSelect  <= 1'b1;
        outputMemWnR     <= (gnt_sel == DATA) && inputDataWnR;
        outputMemAddress <= (gnt_sel == DATA) ? inputDataAddress : inputFetchAddress;
        outputMemWdata   <= (gnt_sel == DATA) ? inputDataWdata : '0;
      end else if (finish) begin
        outputMemSelect  <= 1'b0;
      end
      if (finish) begin
        if (gnt_q == FETCH) outputFetchRdata <= cap_data;
        else                outputDataRdata  <= cap_data;
      end
    end
  end

  assign outputFetchDone = (state_q == DONE) && (gnt_q == FETCH);
  assign outputDataDone  = (state_q == DONE) && (gnt_q == DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             err_q;

  assign abort       = (state_q == ACCESS) && !inputMemValid && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign outputError = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= abort;
      if (load)                  to_cnt_q <= '0;
      else if (state_q == ACCESS) to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign outputError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench: word memory model, transaction-level arbiter model, directed + random traffic.
module tb_mem_access_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_rdata;
  logic          f_done;
  logic          d_req = 1'b0;
  logic          d_wnr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          m_sel, m_wnr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_valid = 1'b0;
  logic          mem_blk = 1'b0;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  mem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .inputFetchReq     (f_req),
    .inputFetchAddress (f_addr),
    .outputFetchRdata  (f_rdata),
    .outputFetchDone   (f_done),
    .inputDataReq      (d_req),
    .inputDataWnR      (d_wnr),
    .inputDataAddress  (d_addr),
    .inputDataWdata    (d_wdata),
    .outputDataRdata   (d_rdata),
    .outputDataDone    (d_done),
    .outputMemSelect   (m_sel),
    .outputMemWnR      (m_wnr),
    .outputMemAddress  (m_addr),
    .outputMemWdata    (m_wdata),
    .inputMemRdata     (mem_rdata),
    .inputMemValid     (mem_valid),
    .outputError       (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Word memory: samples select when not already completing, answers one cycle later.
  // Read data is garbage except on a read valid pulse.
  always @(posedge clk) begin
    mem_rdata <= DW'($urandom);
    if (mem_valid) mem_valid <= 1'b0;
    else if (m_sel && !mem_blk) begin
      mem_valid <= 1'b1;
      if (m_wnr) mem[m_addr] <= m_wdata;
      else       mem_rdata   <= mem[m_addr];
    end
  end

  // Transaction-level model: an access accepted in cycle t0 owns the bus for t0+1..t0+dph-1,
  // completes in cycle t0+dph; on contention the port not served last goes first.
  int            cyc = 0;
  bit            mb = 0, ms = 0, mlast = 0, mwnr = 0, mblk = 0;
  int            mt0 = 0, mdph = 3;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwd = '0, mfrd = '0, mdrd = '0;

  always @(negedge clk) begin
    bit es, efd, edd, eerr, exv, fr, dr;
    cyc++;
    if (rst) begin
      if (mb && mwnr && !mblk && (cyc - mt0) >= 2) ref_mem[maddr] = mwd;
      mb = 0; mlast = 0; mfrd = '0; mdrd = '0;
      chk("rst_ctl", {f_done, d_done, m_sel, m_wnr, err}, 0);
      chk("rst_rdata", {f_rdata, d_rdata}, 0);
      chk("rst_membus", {m_addr, m_wdata}, 0);
    end else begin
      es = 0; efd = 0; edd = 0; eerr = 0; exv = 0;
      if (mb) begin
        if (cyc - mt0 == mdph) begin
          if (ms) begin
            edd  = 1;
            mdrd = (mwnr || mblk) ? '0 : ref_mem[maddr];
            if (mwnr && !mblk) ref_mem[maddr] = mwd;
          end else begin
            efd  = 1;
            mfrd = mblk ? '0 : ref_mem[maddr];
          end
          eerr = mblk; mb = 0; exv = 1;
        end else es = 1;
      end
      chk("fetch_done", f_done, efd);
      chk("data_done", d_done, edd);
      chk("fetch_rdata", f_rdata, mfrd);
      chk("data_rdata", d_rdata, mdrd);
      chk("error", err, eerr);
      chk("mem_sel", m_sel, es);
      if (es) begin
        chk("mem_addr", m_addr, maddr);
        chk("mem_wnr", m_wnr, mwnr);
        if (mwnr) chk("mem_wdata", m_wdata, mwd);
      end
      if (!mb) begin
        fr = f_req && !(exv && !ms);
        dr = d_req && !(exv && ms);
        if (fr || dr) begin
          ms    = (fr && dr) ? !mlast : dr;
          mlast = ms; mb = 1; mt0 = cyc;
          maddr = ms ? d_addr : f_addr;
          mwnr  = ms && d_wnr;
          mwd   = d_wdata;
          mblk  = mem_blk;
          mdph  = 3;
`ifdef MEM_ARB_TIMEOUT_EN
          if (mblk) mdph = TO + 2;
`else
          if (mblk) mdph = 1 << 30;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One request on one port; lat counts cycles from the request cycle to its Done.
  task automatic access(input bit port, input bit wnr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int bound, output int lat,
                        output logic [DW-1:0] rd, output logic [3:0] selh,
                        output bit other, output bit er);
    tick();
    if (port) begin d_req = 1; d_wnr = wnr; d_addr = a; d_wdata = wd; end
    else begin f_req = 1; f_addr = a; end
    lat = 0; selh = '0; other = 0;
    do begin
      tick(); lat++;
      if (lat < 4) selh[lat] = m_sel;
      if (port ? f_done : d_done) other = 1;
    end while (!(port ? d_done : f_done) && lat < bound);
    rd = port ? d_rdata : f_rdata;
    er = err;
    if (port) d_req = 0; else f_req = 0;
  endtask

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) a = a | 16'hF000;
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    int lat, n, extra;
    logic [DW-1:0] rd;
    logic [3:0] selh;
    bit other, er, fpd, dpd, seen;
    logic [5:0] seqb;
    int when[6];
    int cnt;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = DW'(i) ^ 16'h5A5A;
      ref_mem[i] = DW'(i) ^ 16'h5A5A;
    end
    mem[5] = 16'h1234; ref_mem[5] = 16'h1234;

    repeat (3) tick();
    chk("reset_sel", m_sel, 0);
    chk("reset_done", {f_done, d_done}, 0);
    #1 rst = 0;
    repeat (2) tick();

    // Data write then read back.
    access(1, 1, 16'h0040, 16'hBEEF, 40, lat, rd, selh, other, er);
    chk("wr_latency", lat, 3);
    chk("wr_rdata", rd, 16'h0000);
    access(1, 0, 16'h0040, 16'h0000, 40, lat, rd, selh, other, er);
    chk("rd_latency", lat, 3);
    chk("rd_rdata", rd, 16'hBEEF);

    // Fetch of a preloaded word.
    access(0, 0, 16'h0005, 16'h0000, 40, lat, rd, selh, other, er);
    chk("fetch_latency", lat, 3);
    chk("fetch_rdata_lit", rd, 16'h1234);
    chk("fetch_sel_window", selh[3:1], 3'b011);
    chk("fetch_no_data_done", other, 0);

    // Both ports requesting together and held: alternate starting with data.
    tick();
    f_req = 1; f_addr = 16'h0005;
    d_req = 1; d_wnr = 0; d_addr = 16'h0040;
    n = 0; cnt = 0; extra = 0; seqb = '0;
    while (cnt < 6 && n < 40) begin
      tick(); n++;
      if (f_done || d_done) begin
        seqb[cnt] = d_done; when[cnt] = n; cnt++;
      end else if (!m_sel && cnt >= 1 && cnt < 6) extra++;
    end
    f_req = 0; d_req = 0;
    chk("contention_count", cnt, 6);
    chk("contention_order", seqb, 6'b010101);
    chk("contention_first", when[0], 3);
    for (int i = 1; i < 6; i++) chk("contention_spacing", when[i] - when[i-1], 3);
    chk("contention_sel_gap", extra, 0);
    repeat (2) tick();

    // Reset in the middle of an access.
    f_req = 1; f_addr = 16'h0005;
    tick();
    tick();
    #1 rst = 1;
    #1;
    chk("async_rst_sel", m_sel, 0);
    chk("async_rst_rdata", f_rdata, 0);
    seen = 0;
    repeat (2) begin tick(); if (f_done || d_done) seen = 1; end
    chk("rst_no_done", seen, 0);
    #1 rst = 0;
    n = 0;
    do begin tick(); n++; end while (!f_done && n < 40);
    chk("rst_reissue_latency", n, 3);
    chk("rst_reissue_rdata", f_rdata, 16'h1234);
    f_req = 0;
    repeat (2) tick();

    // Random traffic on both ports.
    fpd = 0; dpd = 0;
    repeat (800) begin
      tick();
      if (fpd) f_req = 0;
      if (dpd) d_req = 0;
      if (!f_req && $urandom_range(0, 99) < 35) begin f_req = 1; f_addr = raddr(); end
      if (!d_req && $urandom_range(0, 99) < 35) begin
        d_req = 1; d_wnr = 1'($urandom_range(0, 1)); d_addr = raddr(); d_wdata = DW'($urandom);
      end
      fpd = f_done; dpd = d_done;
    end
    n = 0;
    while ((f_req || d_req) && n < 50) begin
      tick(); n++;
      if (fpd) f_req = 0;
      if (dpd) d_req = 0;
      fpd = f_done; dpd = d_done;
    end
    chk("random_drain", {f_req, d_req}, 0);
    repeat (3) tick();

    // Memory never answers.
    mem_blk = 1;
`ifdef MEM_ARB_TIMEOUT_EN
    access(1, 0, 16'h0040, 16'h0000, 40, lat, rd, selh, other, er);
    chk("timeout_latency", lat, TO + 2);
    chk("timeout_rdata", rd, 16'h0000);
    chk("timeout_error", er, 1);
`else
    access(1, 0, 16'h0040, 16'h0000, 100, lat, rd, selh, other, er);
    chk("no_timeout_wait", lat, 100);
    chk("no_timeout_done", d_done, 0);
`endif
    mem_blk = 0;
    #1 rst = 1;
    repeat (2) tick();
    #1 rst = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
